// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam logic        LINE_IDLE      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bus of the UART transmitter: enable/data in, line/busy out.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF
);
    logic                  en;
    logic [DATA_WIDTH-1:0] data;
    logic                  tx;
    logic                  busy;

    modport master (output en, output data, input tx, input busy);
    modport slave  (input en, input data, output tx, output busy);
endinterface

// File: rtl/uart_tick_edge.sv
// Rising-edge detector on the external baud reference; one-clk strobe per edge.
module uart_tick_edge
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    output logic tick
);

    logic baud_q;

    // Delayed copy of baud_tick; resets high so a level already high is not an edge
    always_ff @(posedge clk) begin
        if (rst) baud_q <= 1'b1;
        else     baud_q <= baud_tick;
    end

    assign tick = baud_tick & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter driven by an external baud strobe.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_tick,
    uart_tx_if.slave    bus
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  tick;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    uart_tick_edge u_tick_edge (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .tick      (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; transitions only on baud strobe
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:    if (bus.en) state_d = START;
                START:   state_d = DATA;
`ifdef UART_TX_PARITY_EN
                DATA:    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = PARITY;
                PARITY:  state_d = STOP;
`else
                DATA:    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = STOP;
`endif
                STOP:    state_d = bus.en ? START : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: line level, busy, shifter, bit counter
    always_comb begin
        tx_d    = tx_q;
        busy_d  = busy_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE, STOP: begin
                    if (bus.en) begin
                        shift_d = bus.data;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^bus.data;
`endif
                    end else begin
                        tx_d   = LINE_IDLE;
                        busy_d = 1'b0;
                    end
                end
                START: begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                end
                DATA: begin
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = parity_q;
`else
                        tx_d = LINE_IDLE;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: tx_d = LINE_IDLE;
`endif
                default: tx_d = LINE_IDLE;
            endcase
        end
    end

    // Datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FRAME_LEN = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int FRAME_LEN = 10;
`endif
    localparam int SLOW = 130;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;

    int errors = 0;
    int checks = 0;

    logic rec_sq [0:FRAME_LEN*SLOW-1];
    logic rec_pl [0:FRAME_LEN*SLOW-1];

    uart_tx_if #(.DATA_WIDTH(8)) ifc ();

    uart_tx #(.DATA_WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .bus       (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR && k == 9) return ^d;
        return 1'b1;
    endfunction

    // One baud period: high for hi clks, low for the rest; ends at posedge+1
    task automatic tick_wave(input int period, input int hi);
        baud_tick = 1'b1;
        for (int c = 0; c < period; c++) begin
            @(posedge clk); #1;
            if (c == hi - 1) baud_tick = 1'b0;
        end
    endtask

    // Drive and check one full frame; en is set to keep_en after the start tick
    task automatic run_frame(input string name, input logic [7:0] d, input bit keep_en,
                             input int sw_at, input logic [7:0] sw_data);
        for (int k = 0; k < FRAME_LEN; k++) begin
            tick_wave(4, (k % 2) + 1);
            if (k == 0) ifc.en = keep_en;
            if (k == sw_at) ifc.data = sw_data;
            check($sformatf("%s tx bit%0d", name, k), 32'(ifc.tx), 32'(frame_bit(d, k)));
            check($sformatf("%s busy bit%0d", name, k), 32'(ifc.busy), 32'd1);
        end
    endtask

    task automatic idle_tick(input string name);
        tick_wave(4, 1);
        check($sformatf("%s idle tx", name), 32'(ifc.tx), 32'd1);
        check($sformatf("%s idle busy", name), 32'(ifc.busy), 32'd0);
    endtask

    // Record one frame clock by clock with the given baud high time
    task automatic slow_frame(input int hi, input bit sel);
        ifc.data = 8'hB4;
        ifc.en   = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            baud_tick = 1'b1;
            for (int c = 0; c < SLOW; c++) begin
                @(posedge clk); #1;
                if (sel) rec_pl[k*SLOW+c] = ifc.tx;
                else     rec_sq[k*SLOW+c] = ifc.tx;
                if (c == hi - 1) baud_tick = 1'b0;
                if (k == 0 && c == 0) ifc.en = 1'b0;
            end
        end
        tick_wave(SLOW, hi);
        check($sformatf("slow hi=%0d idle busy", hi), 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        int bad;
        ifc.en   = 1'b0;
        ifc.data = 8'h00;

        // Reset held with baud_tick toggling
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            baud_tick = ~baud_tick;
            check($sformatf("reset tx %0d", i), 32'(ifc.tx), 32'd1);
            check($sformatf("reset busy %0d", i), 32'(ifc.busy), 32'd0);
        end
        // Release with baud_tick high and en high: no false edge
        baud_tick = 1'b1;
        ifc.en = 1'b1;
        ifc.data = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no false edge tx", 32'(ifc.tx), 32'd1);
        check("no false edge busy", 32'(ifc.busy), 32'd0);
        ifc.en = 1'b0;
        baud_tick = 1'b0;
        @(posedge clk); #1;

        // Single frame
        ifc.data = 8'hB4;
        ifc.en = 1'b1;
        run_frame("single", 8'hB4, 1'b0, -1, 8'h00);
        idle_tick("single");
        idle_tick("single hold");

        // Back-to-back frames
        ifc.en = 1'b1;
        run_frame("b2b f1", 8'hB4, 1'b1, -1, 8'h00);
        run_frame("b2b f2", 8'hB4, 1'b1, -1, 8'h00);
        run_frame("b2b f3", 8'hB4, 1'b0, -1, 8'h00);
        idle_tick("b2b");

        // Data change mid-frame
        ifc.data = 8'hB4;
        ifc.en = 1'b1;
        run_frame("chg f1", 8'hB4, 1'b1, 4, 8'h5A);
        run_frame("chg f2", 8'h5A, 1'b0, -1, 8'h00);
        idle_tick("chg");

        // Mid-frame abort during data bit 4
        ifc.data = 8'hA5;
        ifc.en = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick_wave(4, 1);
            if (k == 0) ifc.en = 1'b0;
        end
        check("abort pre tx", 32'(ifc.tx), 32'(frame_bit(8'hA5, 5)));
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort tx", 32'(ifc.tx), 32'd1);
        check("abort busy", 32'(ifc.busy), 32'd0);
        rst = 1'b0;
        idle_tick("post abort 1");
        idle_tick("post abort 2");
        ifc.data = 8'h5A;
        ifc.en = 1'b1;
        run_frame("post abort", 8'h5A, 1'b0, -1, 8'h00);
        idle_tick("post abort end");

        // Square-wave versus pulse baud reference
        slow_frame(SLOW / 2, 1'b0);
        slow_frame(1, 1'b1);
        bad = 0;
        for (int j = 0; j < FRAME_LEN * SLOW; j++)
            if (rec_sq[j] !== frame_bit(8'hB4, j / SLOW)) bad++;
        check("square wave bit timing", 32'(bad), 32'd0);
        bad = 0;
        for (int j = 0; j < FRAME_LEN * SLOW; j++)
            if (rec_pl[j] !== frame_bit(8'hB4, j / SLOW)) bad++;
        check("pulse bit timing", 32'(bad), 32'd0);
        bad = 0;
        for (int j = 0; j < FRAME_LEN * SLOW; j++)
            if (rec_sq[j] !== rec_pl[j]) bad++;
        check("square vs pulse", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
